// File: rtl/jt12_timer_pkg.sv
// -----------------------------------------------------------------------------
// jt12_timer_pkg
// Shared constants for the jt12 interval-timer bank.
//   - Channel state encodings (IDLE / COUNT / DONE).
//   - Reference geometries of the two YM2612 timers:
//       timer A: 10-bit counter, no prescaling (1-bit prescaler held at 0)
//       timer B:  8-bit counter, divide-by-16 prescaler
//   - Default bank geometry used by jt12_timer_bank.
// -----------------------------------------------------------------------------
package jt12_timer_pkg;

    // Channel states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // YM2612 timer A: counts every tick, 10-bit counter
    localparam int TMRA_CW      = 10;
    localparam int TMRA_PW      = 1;
    localparam int TMRA_PRE_MAX = 0;

    // YM2612 timer B: 8-bit counter advancing every 16 ticks
    localparam int TMRB_CW      = 8;
    localparam int TMRB_PW      = 4;
    localparam int TMRB_PRE_MAX = 15;

    // Default bank geometry: timer-A width with a prescaler wide enough for B
    localparam int DEF_NCH = 2;
    localparam int DEF_CW  = TMRA_CW;
    localparam int DEF_PW  = TMRB_PW;

endpackage

// File: rtl/jt12_timer_ch.sv
// -----------------------------------------------------------------------------
// jt12_timer_ch
// One up-counting interval timer with runtime prescaler, one-shot/continuous
// mode, sticky overflow flag and a single-cycle overflow pulse.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   i_tick_en       tick request (cen | fast) shared by the bank
//   i_start_value   reload value, sampled only at load/reload
//   i_pre_max       prescaler terminal count, live
//   i_run           level run control; rising edge loads and starts
//   i_oneshot       stop in DONE after the first overflow
//   i_clr_flag      clears the sticky flag (overflow set wins)
//   o_flag          sticky overflow flag
//   o_ovf           one-clk overflow pulse
//   o_active        channel is counting
//   o_cnt           live counter value
// -----------------------------------------------------------------------------
module jt12_timer_ch
    import jt12_timer_pkg::*;
#(
    parameter int CW = 10,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_tick_en,
    input  logic [CW-1:0] i_start_value,
    input  logic [PW-1:0] i_pre_max,
    input  logic          i_run,
    input  logic          i_oneshot,
    input  logic          i_clr_flag,
    output logic          o_flag,
    output logic          o_ovf,
    output logic          o_active,
    output logic [CW-1:0] o_cnt
);

    logic [1:0]    r_state;
    logic [PW-1:0] r_pre;
    logic [CW-1:0] r_cnt;
    logic          r_flag;
    logic          r_ovf;
    logic          r_run_d;

    logic w_active;
    logic w_tick;
    logic w_rise;
    logic w_pre_end;
    logic w_ovf;

    assign w_active  = (r_state == ST_COUNT);
    assign w_tick    = i_tick_en & w_active;
    assign w_rise    = i_run & ~r_run_d;
    // Equality only: when pre_max is lowered below pre, the prescaler runs on
    // and wraps through 2^PW before matching again.
    assign w_pre_end = (r_pre == i_pre_max);
    // A load on the run edge, or dropping run, suppresses any overflow.
    assign w_ovf     = w_tick & w_pre_end & (&r_cnt) & i_run & ~w_rise;

    // NOTE: reset is sampled synchronously; every state register here is a
    // plain flop (no memory arrays), so all of them are cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_flag  <= 1'b0;
            r_ovf   <= 1'b0;
            r_run_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the pre-edge register values.
            r_run_d <= i_run;
            r_ovf   <= w_ovf;

            if (w_rise) begin
                r_cnt   <= i_start_value;
                r_pre   <= '0;
                r_state <= ST_COUNT;
            end else if (!i_run) begin
                r_state <= ST_IDLE;          // cnt and pre hold
            end else if (w_tick) begin
                if (!w_pre_end) begin
                    r_pre <= r_pre + 1'b1;
                end else begin
                    r_pre <= '0;
                    if (&r_cnt) begin
                        r_cnt <= i_start_value;
                        if (i_oneshot) r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Overflow set takes precedence over a simultaneous clear.
            if (w_ovf)           r_flag <= 1'b1;
            else if (i_clr_flag) r_flag <= 1'b0;
        end
    end

    assign o_flag   = r_flag;
    assign o_ovf    = r_ovf;
    assign o_active = w_active;
    assign o_cnt    = r_cnt;

endmodule

// File: rtl/jt12_timer_bank.sv
// -----------------------------------------------------------------------------
// jt12_timer_bank
// Bank of NCH independent interval timers for FM/PSG sound cores.
//
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   cen           clock enable; one tick per enabled cycle
//   fast          test mode; tick every clk regardless of cen
//   start_value   NCH*CW reload values, channel i at [i*CW +: CW]
//   pre_max       NCH*PW prescaler terminal counts, channel i at [i*PW +: PW]
//   run           per-channel run level
//   oneshot       per-channel one-shot mode
//   irq_en        per-channel interrupt enable
//   clr_flag      per-channel flag clear pulse
//   flag          sticky overflow flags
//   ovf           one-clk overflow pulses
//   active        per-channel counting indicator
//   cnt           NCH*CW live counter values
//   irq_n         active-low interrupt, OR of enabled flags
// -----------------------------------------------------------------------------
module jt12_timer_bank
    import jt12_timer_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = DEF_CW,
    parameter int PW  = DEF_PW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              fast,
    input  logic [NCH*CW-1:0] start_value,
    input  logic [NCH*PW-1:0] pre_max,
    input  logic [NCH-1:0]    run,
    input  logic [NCH-1:0]    oneshot,
    input  logic [NCH-1:0]    irq_en,
    input  logic [NCH-1:0]    clr_flag,
    output logic [NCH-1:0]    flag,
    output logic [NCH-1:0]    ovf,
    output logic [NCH-1:0]    active,
    output logic [NCH*CW-1:0] cnt,
    output logic              irq_n
);

    logic w_tick_en;

    assign w_tick_en = cen | fast;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        jt12_timer_ch #(
            .CW (CW),
            .PW (PW)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_tick_en     (w_tick_en),
            .i_start_value (start_value[g*CW +: CW]),
            .i_pre_max     (pre_max[g*PW +: PW]),
            .i_run         (run[g]),
            .i_oneshot     (oneshot[g]),
            .i_clr_flag    (clr_flag[g]),
            .o_flag        (flag[g]),
            .o_ovf         (ovf[g]),
            .o_active      (active[g]),
            .o_cnt         (cnt[g*CW +: CW])
        );
    end

    // Masking with irq_en drops the interrupt without touching the flags.
    assign irq_n = ~|(flag & irq_en);

endmodule

// File: tb/tb_jt12_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_jt12_timer_bank
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared every cycle against a behavioural model of the timer rules.
// -----------------------------------------------------------------------------
module tb_jt12_timer_bank;

    localparam int NCH  = 2;
    localparam int CW   = 10;
    localparam int PW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int PMOD = 1 << PW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cen = 1'b0;
    logic              fast = 1'b0;
    logic [NCH*CW-1:0] start_value = '0;
    logic [NCH*PW-1:0] pre_max = '0;
    logic [NCH-1:0]    run = '0;
    logic [NCH-1:0]    oneshot = '0;
    logic [NCH-1:0]    irq_en = '0;
    logic [NCH-1:0]    clr_flag = '0;
    logic [NCH-1:0]    flag;
    logic [NCH-1:0]    ovf;
    logic [NCH-1:0]    active;
    logic [NCH*CW-1:0] cnt;
    logic              irq_n;

    jt12_timer_bank #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .fast        (fast),
        .start_value (start_value),
        .pre_max     (pre_max),
        .run         (run),
        .oneshot     (oneshot),
        .irq_en      (irq_en),
        .clr_flag    (clr_flag),
        .flag        (flag),
        .ovf         (ovf),
        .active      (active),
        .cnt         (cnt),
        .irq_n       (irq_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_COUNT, M_DONE} mode_t;
    mode_t m_mode [NCH];
    int    m_cnt  [NCH];
    int    m_pre  [NCH];
    int    m_flag [NCH];
    int    m_ovf  [NCH];
    int    m_rund [NCH];

    function automatic int sv_of(input int ch);
        return int'(start_value[ch*CW +: CW]);
    endfunction

    function automatic int pm_of(input int ch);
        return int'(pre_max[ch*PW +: PW]);
    endfunction

    task automatic model_edge();
        for (int ch = 0; ch < NCH; ch++) begin
            if (!rst_n) begin
                m_mode[ch] = M_IDLE; m_cnt[ch] = 0; m_pre[ch] = 0;
                m_flag[ch] = 0;      m_ovf[ch] = 0; m_rund[ch] = 0;
            end else begin
                bit rise = run[ch] && !m_rund[ch];
                bit tick = (cen || fast) && (m_mode[ch] == M_COUNT);
                m_ovf[ch] = 0;
                if (rise) begin
                    m_cnt[ch] = sv_of(ch); m_pre[ch] = 0; m_mode[ch] = M_COUNT;
                end else if (!run[ch]) begin
                    m_mode[ch] = M_IDLE;
                end else if (tick) begin
                    if (m_pre[ch] != pm_of(ch)) begin
                        m_pre[ch] = (m_pre[ch] + 1) % PMOD;
                    end else begin
                        m_pre[ch] = 0;
                        if (m_cnt[ch] == CMAX) begin
                            m_cnt[ch] = sv_of(ch);
                            m_ovf[ch] = 1;
                            if (oneshot[ch]) m_mode[ch] = M_DONE;
                        end else begin
                            m_cnt[ch] = m_cnt[ch] + 1;
                        end
                    end
                end
                if (m_ovf[ch] != 0)    m_flag[ch] = 1;
                else if (clr_flag[ch]) m_flag[ch] = 0;
                m_rund[ch] = run[ch];
            end
        end
    endtask

    task automatic compare_all();
        int any_irq = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("ch%0d_cnt", ch),    int'(cnt[ch*CW +: CW]), m_cnt[ch]);
            check($sformatf("ch%0d_flag", ch),   int'(flag[ch]),   m_flag[ch]);
            check($sformatf("ch%0d_ovf", ch),    int'(ovf[ch]),    m_ovf[ch]);
            check($sformatf("ch%0d_active", ch), int'(active[ch]), (m_mode[ch] == M_COUNT) ? 1 : 0);
            if (m_flag[ch] != 0 && irq_en[ch]) any_irq = 1;
        end
        check("irq_n", int'(irq_n), any_irq ? 0 : 1);
    endtask

    // One clock edge: update the model with the inputs present at the edge,
    // then compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_ovf(input int ch, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ovf[ch] && n <= limit);
    endtask

    task automatic set_ch(input int ch, input int sv, input int pm);
        start_value[ch*CW +: CW] = CW'(sv);
        pre_max[ch*PW +: PW]     = PW'(pm);
    endtask

    function automatic int cnt_of(input int ch);
        return int'(cnt[ch*CW +: CW]);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int g;
        int first;
        int second;
        int ovf_seen;

        // Reset
        step(); step();
        check("rst_cnt", int'(cnt), 0);
        check("rst_flag", int'(flag), 0);
        check("rst_active", int'(active), 0);
        check("rst_irq_n", int'(irq_n), 1);
        rst_n  = 1'b1;
        irq_en = '1;
        cen    = 1'b1;
        step();

        // Continuous reload, 4-tick period
        set_ch(0, 1020, 0);
        run[0] = 1'b1;
        step();
        check("cont_load_cnt", cnt_of(0), 1020);
        check("cont_load_active", int'(active[0]), 1);
        wait_ovf(0, 20, n);
        check("cont_first_period", n, 4);
        check("cont_wrap_cnt", cnt_of(0), 1020);
        check("cont_flag", int'(flag[0]), 1);
        check("cont_irq_n", int'(irq_n), 0);
        wait_ovf(0, 20, n);
        check("cont_second_period", n, 4);

        // Flag race: clear on the overflow edge, then clear alone
        step(); step(); step();
        clr_flag[0] = 1'b1;
        step();
        check("race_ovf", int'(ovf[0]), 1);
        check("race_flag_kept", int'(flag[0]), 1);
        step();
        check("clr_flag", int'(flag[0]), 0);
        check("clr_irq_n", int'(irq_n), 1);
        clr_flag[0] = 1'b0;
        wait_ovf(0, 20, n);
        irq_en[0] = 1'b0;
        step();
        check("mask_flag_kept", int'(flag[0]), 1);
        check("mask_irq_n", int'(irq_n), 1);
        irq_en[0] = 1'b1;
        run[0] = 1'b0;
        step();

        // Hold and reload
        set_ch(0, 1000, 0);
        run[0] = 1'b1;
        step();
        g = 0;
        while (cnt_of(0) != 1021 && g < 100) begin
            step();
            g++;
        end
        check("hold_reached", cnt_of(0), 1021);
        run[0] = 1'b0;
        step();
        repeat (50) step();
        check("hold_cnt", cnt_of(0), 1021);
        check("hold_active", int'(active[0]), 0);
        run[0] = 1'b1;
        step();
        check("reload_cnt", cnt_of(0), 1000);
        check("reload_active", int'(active[0]), 1);
        step(); step();

        // Reset mid-count with run held high
        rst_n = 1'b0;
        step();
        check("midrst_cnt", cnt_of(0), 0);
        check("midrst_active", int'(active[0]), 0);
        check("midrst_flag", int'(flag), 0);
        check("midrst_irq_n", int'(irq_n), 1);
        rst_n = 1'b1;
        step();
        check("postrst_cnt", cnt_of(0), 1000);
        check("postrst_active", int'(active[0]), 1);
        run[0] = 1'b0;
        step();

        // One-shot
        oneshot[0] = 1'b1;
        set_ch(0, 1022, 0);
        run[0] = 1'b1;
        step();
        wait_ovf(0, 20, n);
        check("oneshot_period", n, 2);
        check("oneshot_done_active", int'(active[0]), 0);
        ovf_seen = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (ovf[0]) ovf_seen++;
        end
        check("oneshot_silent", ovf_seen, 0);
        run[0] = 1'b0;
        step();
        run[0] = 1'b1;
        step();
        check("oneshot_rearm_cnt", cnt_of(0), 1022);
        wait_ovf(0, 20, n);
        check("oneshot_rearm_period", n, 2);
        run[0] = 1'b0;
        oneshot[0] = 1'b0;
        clr_flag = '1;
        step();
        clr_flag = '0;

        // Prescaler: cen every 3rd clk, then fast mode
        set_ch(1, 1023, 15);
        cen = 1'b0;
        run[1] = 1'b1;
        step();
        first  = -1;
        second = -1;
        for (int k = 1; k <= 120; k++) begin
            cen = (k % 3 == 0);
            step();
            if (ovf[1]) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        check("pre_first_ovf_clk", first, 48);
        check("pre_second_ovf_clk", second, 96);
        cen  = 1'b0;
        fast = 1'b1;
        wait_ovf(1, 60, n);
        wait_ovf(1, 60, n);
        check("fast_period", n, 16);
        fast = 1'b0;
        run[1] = 1'b0;
        cen = 1'b1;
        step();

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            cen   = ($urandom_range(0, 2) != 0);
            fast  = ($urandom_range(0, 24) == 0);
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 39) == 0) run[ch] = ~run[ch];
                if ($urandom_range(0, 59) == 0) oneshot[ch] = ~oneshot[ch];
                if ($urandom_range(0, 29) == 0)
                    start_value[ch*CW +: CW] = CW'($urandom_range(1000, 1023));
                if ($urandom_range(0, 49) == 0)
                    pre_max[ch*PW +: PW] = PW'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) irq_en[ch] = ~irq_en[ch];
                clr_flag[ch] = ($urandom_range(0, 9) == 0);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
